// File: rtl/transition_energy_meter.sv
// Counts 0->1 transitions on monitored gate outputs over a cycle window and reports energy.
// Optional per-line rise counters are enabled by defining TEM_PERLINE_EN.
module transition_energy_meter #(
  parameter int unsigned N_LINES     = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned E_PER_TRANS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_LINES-1:0]    y_in,
  input  logic [CNT_W-1:0]      window_len,
  input  logic                  start,
  input  logic                  ack,
  output logic                  busy,
  output logic                  valid,
`ifdef TEM_PERLINE_EN
  output logic [N_LINES*8-1:0]  line_cnt,
`endif
  output logic [CNT_W-1:0]      trans_total,
  output logic [CNT_W+7:0]      energy
);

  localparam int unsigned SUM_W = CNT_W + 8;
  localparam int unsigned PW    = CNT_W + 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [N_LINES-1:0] prev_q, prev_d;
  logic [N_LINES-1:0] rise;
  logic [SUM_W-1:0]   sum;
  logic [PW-1:0]      prod;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (window_len == '0) ? DONE : RUN;
      RUN:  if (remaining_q <= CNT_W'(1)) state_d = DONE;
      DONE: if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN);
    valid = (state_q == DONE);
  end

  // Wide accumulator so the saturation test sees the true sum before clamping.
  always_comb begin
    rise = y_in & ~prev_q;
    sum  = SUM_W'(total_q);
    for (int unsigned i = 0; i < N_LINES; i++) begin
      sum = sum + SUM_W'(rise[i]);
    end
  end

  always_comb begin
    remaining_d = remaining_q;
    total_d     = total_q;
    prev_d      = prev_q;
    case (state_q)
      IDLE: if (start) begin
        remaining_d = window_len;
        prev_d      = y_in;
        total_d     = '0;
      end
      RUN: begin
        total_d     = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
        prev_d      = y_in;
        remaining_d = remaining_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining_q <= '0;
      total_q     <= '0;
      prev_q      <= '0;
    end else begin
      remaining_q <= remaining_d;
      total_q     <= total_d;
      prev_q      <= prev_d;
    end
  end

  // Energy is derived from the registered total, so it is coherent with valid.
  always_comb begin
    prod        = PW'(total_q) * PW'(E_PER_TRANS);
    energy      = (prod > PW'({(CNT_W+8){1'b1}})) ? '1 : prod[CNT_W+7:0];
    trans_total = total_q;
  end

`ifdef TEM_PERLINE_EN
  logic [7:0] lc_q [N_LINES];
  logic [7:0] lc_d [N_LINES];

  always_comb begin
    for (int unsigned i = 0; i < N_LINES; i++) begin
      lc_d[i] = lc_q[i];
      if (state_q == IDLE && start)
        lc_d[i] = '0;
      else if (state_q == RUN && rise[i] && lc_q[i] != 8'hFF)
        lc_d[i] = lc_q[i] + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (reset) lc_q[i] <= '0;
      else       lc_q[i] <= lc_d[i];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_LINES; i++) begin
      line_cnt[i*8 +: 8] = lc_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_transition_energy_meter.sv
// Randomized bench for transition_energy_meter: three parameterisations share one stimulus
// stream and are checked against a window-level transition-count model.
module tb_transition_energy_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  y_in;
  logic [15:0] window_len;
  logic        start, ack;

  logic        busy_a, valid_a, busy_b, valid_b, busy_c, valid_c;
  logic [15:0] tt_a;
  logic [23:0] en_a;
  logic [3:0]  tt_b, tt_c;
  logic [11:0] en_b, en_c;
`ifdef TEM_PERLINE_EN
  logic [31:0] lc_a, lc_b, lc_c;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] ys [0:15];

  always #5 clk = ~clk;

  transition_energy_meter u_dut_a (
    .clk(clk), .reset(reset), .y_in(y_in), .window_len(window_len),
    .start(start), .ack(ack), .busy(busy_a), .valid(valid_a),
`ifdef TEM_PERLINE_EN
    .line_cnt(lc_a),
`endif
    .trans_total(tt_a), .energy(en_a));

  transition_energy_meter #(.N_LINES(4), .CNT_W(4), .E_PER_TRANS(3)) u_dut_b (
    .clk(clk), .reset(reset), .y_in(y_in), .window_len(window_len[3:0]),
    .start(start), .ack(ack), .busy(busy_b), .valid(valid_b),
`ifdef TEM_PERLINE_EN
    .line_cnt(lc_b),
`endif
    .trans_total(tt_b), .energy(en_b));

  transition_energy_meter #(.N_LINES(4), .CNT_W(4), .E_PER_TRANS(300)) u_dut_c (
    .clk(clk), .reset(reset), .y_in(y_in), .window_len(window_len[3:0]),
    .start(start), .ack(ack), .busy(busy_c), .valid(valid_c),
`ifdef TEM_PERLINE_EN
    .line_cnt(lc_c),
`endif
    .trans_total(tt_c), .energy(en_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ys[0] is presented with start; ys[1..w] are presented during the window.
  task automatic run_meas(input string tag, input int w, input int hold, input bit start_at_ack);
    int raw;
    int lc [4];
    logic [3:0] r;
    int ta, tb, ea, eb, ec;
    raw = 0;
    for (int b = 0; b < 4; b++) lc[b] = 0;
    for (int i = 1; i <= w; i++) begin
      r = ys[i] & ~ys[i-1];
      raw += $countones(r);
      for (int b = 0; b < 4; b++) lc[b] += int'(r[b]);
    end
    ta = (raw > 65535) ? 65535 : raw;
    tb = (raw > 15) ? 15 : raw;
    ea = ta * 3;
    eb = tb * 3;
    ec = (tb * 300 > 4095) ? 4095 : tb * 300;

    y_in = ys[0]; window_len = 16'(w); start = 1'b1; ack = 1'($urandom_range(0, 1));
    tick();
    for (int i = 1; i <= w; i++) begin
      check({tag, ":busy"}, 32'(busy_a), 32'd1);
      check({tag, ":run_valid"}, 32'(valid_a | valid_b), 32'd0);
      y_in = ys[i];
      start = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      window_len = 16'($urandom);
      tick();
    end
    start = 1'b0; ack = 1'b0;
    check({tag, ":done_busy"}, 32'(busy_a | busy_b), 32'd0);
    check({tag, ":valid_a"}, 32'(valid_a), 32'd1);
    check({tag, ":valid_b"}, 32'(valid_b & valid_c), 32'd1);
    check({tag, ":tt_a"}, 32'(tt_a), 32'(ta));
    check({tag, ":en_a"}, 32'(en_a), 32'(ea));
    check({tag, ":tt_b"}, 32'(tt_b), 32'(tb));
    check({tag, ":en_b"}, 32'(en_b), 32'(eb));
    check({tag, ":en_c"}, 32'(en_c), 32'(ec));
`ifdef TEM_PERLINE_EN
    for (int b = 0; b < 4; b++) check({tag, ":line_cnt"}, 32'(lc_a[b*8 +: 8]), 32'(lc[b]));
`endif

    for (int k = 0; k < hold; k++) begin
      start = 1'b1; y_in = 4'($urandom);
      tick();
      check({tag, ":hold_valid"}, 32'(valid_a), 32'd1);
      check({tag, ":hold_tt"}, 32'(tt_a), 32'(ta));
      check({tag, ":hold_en"}, 32'(en_a), 32'(ea));
    end
    ack = 1'b1; start = start_at_ack;
    tick();
    ack = 1'b0; start = 1'b0;
    check({tag, ":ack_valid"}, 32'(valid_a | valid_b), 32'd0);
    check({tag, ":ack_busy"}, 32'(busy_a | busy_b), 32'd0);
    check({tag, ":idle_tt"}, 32'(tt_a), 32'(ta));
    check({tag, ":idle_en"}, 32'(en_a), 32'(ea));
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, ":idle_ack_valid"}, 32'(valid_a), 32'd0);
    check({tag, ":idle_busy"}, 32'(busy_a), 32'd0);
    check({tag, ":idle_keep_tt"}, 32'(tt_b), 32'(tb));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; y_in = '0; window_len = '0; start = 1'b0; ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_valid", 32'(valid_a), 32'd0);
    check("reset_tt", 32'(tt_a), 32'd0);
    check("reset_en", 32'(en_a), 32'd0);

    ys[0] = 4'h0; ys[1] = 4'h1; ys[2] = 4'h0; ys[3] = 4'h1; ys[4] = 4'h0; ys[5] = 4'h0;
    run_meas("toggle5", 5, 3, 1'b1);

    ys[0] = 4'h0; ys[1] = 4'h0; ys[2] = 4'hF; ys[3] = 4'hF; ys[4] = 4'hF;
    run_meas("step4", 4, 0, 1'b0);
    for (int i = 0; i <= 4; i++) ys[i] = 4'hF;
    run_meas("preset4", 4, 1, 1'b0);

    for (int i = 0; i <= 15; i++) ys[i] = (i % 2 == 1) ? 4'hF : 4'h0;
    run_meas("saturate", 15, 0, 1'b0);

    run_meas("zero_win", 0, 2, 1'b1);

    // Abort a 10-cycle window in its third RUN cycle.
    y_in = 4'h0; window_len = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    y_in = 4'hF; tick();
    y_in = 4'h0; tick();
    y_in = 4'hF; reset = 1'b1; start = 1'b1; ack = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; ack = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_valid", 32'(valid_a), 32'd0);
    check("abort_tt", 32'(tt_a), 32'd0);
    check("abort_en", 32'(en_a | 24'(en_c)), 32'd0);
`ifdef TEM_PERLINE_EN
    check("abort_line_cnt", lc_a, 32'd0);
`endif
    for (int i = 0; i < 12; i++) begin
      y_in = 4'($urandom);
      tick();
      check("abort_no_valid", 32'(valid_a | busy_a), 32'd0);
    end

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i <= 15; i++) ys[i] = 4'($urandom);
      run_meas("random", $urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/transition_energy_meter.md
TRANSITION_ENERGY_METER -- requirements
Module: transition_energy_meter

Interface
REQ-001 SHALL have parameter N_LINES, default 4: number of monitored gate outputs (one quad SN74LS02 package).
REQ-002 SHALL have parameter CNT_W, default 16: width of the transition count.
REQ-003 SHALL have parameter E_PER_TRANS, default 3: energy units charged per 0->1 output transition.
REQ-004 SHALL have port clk, input, 1: the block's single clock, rising-edge active.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port y_in, input, N_LINES: gate outputs under observation.
REQ-007 SHALL have port window_len, input, CNT_W: measurement window in clk cycles, sampled on start.
REQ-008 SHALL have port start, input, 1: request to begin a measurement.
REQ-009 SHALL have port ack, input, 1: consumer acknowledgement of a result.
REQ-010 SHALL have port busy, output, 1: high in RUN.
REQ-011 SHALL have port valid, output, 1: high in DONE, result stable.
REQ-012 SHALL have port trans_total, output, CNT_W: rising transitions counted in the window.
REQ-013 SHALL have port energy, output, CNT_W+8: trans_total*E_PER_TRANS.

Function
REQ-014 SHALL implement FSM IDLE, RUN, DONE; only one state active at a time.
REQ-015 In IDLE with start=1 and window_len>0: next state RUN; remaining<=window_len, prev<=y_in, trans_total<=0.
REQ-016 In IDLE with start=1 and window_len=0: next state DONE with trans_total=0, energy=0.
REQ-017 In RUN, each cycle: rise = y_in & ~prev; trans_total += popcount(rise); prev<=y_in; remaining decrements.
REQ-018 RUN SHALL last exactly window_len cycles: when remaining=1, that cycle's edges are counted and next state is DONE.
REQ-019 Edges present on y_in at the start cycle SHALL NOT be counted (prev is preloaded).
REQ-020 trans_total SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 energy SHALL be computed from the final trans_total, saturating at 2^(CNT_W+8)-1; valid and energy are coherent in the same cycle.
REQ-022 start during RUN or DONE SHALL be ignored; window_len changes during RUN have no effect.
REQ-023 In DONE, outputs SHALL hold until ack=1; next state IDLE; valid falls the following cycle.
REQ-024 ack outside DONE SHALL be ignored; start and ack together in DONE: ack wins, return to IDLE, start discarded.
REQ-025 In IDLE, trans_total and energy SHALL retain the last result.

Reset
REQ-026 reset=1 at a clk edge SHALL force IDLE, busy=0, valid=0, trans_total=0, energy=0, prev=0, remaining=0, and per-line counters=0 when present.
REQ-027 reset SHALL take priority over start and ack, aborting any measurement mid-RUN or mid-DONE without producing a result.

Configuration
REQ-028 With macro TEM_PERLINE_EN defined, SHALL add output line_cnt, N_LINES*8 bits: per-line saturating 8-bit rise counters, cleared on start and updated in RUN alongside trans_total, held through DONE/IDLE.
REQ-029 Without TEM_PERLINE_EN, line_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 window_len=5, y_in toggles bit0 0->1->0->1->0 over the window -> after 5 RUN cycles valid=1, trans_total=2, energy=6.
REQ-031 window_len=4, y_in goes 0000->1111 in cycle 2 and holds -> trans_total=4, energy=12; y_in=1111 already at start -> trans_total=0.
REQ-032 CNT_W=4, all four lines toggle every cycle for 16 cycles -> trans_total saturates at 15, energy=45.
REQ-033 window_len=0 with start -> DONE next cycle, trans_total=0, busy never asserted; ack -> valid=0 next cycle.
REQ-034 reset asserted in third cycle of a 10-cycle window -> next cycle IDLE, all outputs 0, no valid pulse.
REQ-035 Hold in DONE with start=1 for 3 cycles, then start=1 and ack=1 together -> result unchanged until ack, returns to IDLE, no new RUN; with TEM_PERLINE_EN, line_cnt matches per-bit rises of REQ-030 (line0=2).
